// File: rtl/golden_nonce_pkg.sv
// Shared constants and serializer state encoding for the golden-nonce UART path.
package golden_nonce_pkg;

    localparam int unsigned NONCE_W            = 32;
    localparam int unsigned NONCE_BYTES        = 4;
    localparam int unsigned UART_BITS_PER_BYTE = 10;
    localparam int unsigned BAUD_CNT_W         = 16;
    localparam logic [7:0]  NONCE_SYNC_BYTE    = 8'hA5;

    typedef logic [2:0] ser_state_t;

    localparam ser_state_t ST_IDLE  = 3'd0;
    localparam ser_state_t ST_LOAD  = 3'd1;
    localparam ser_state_t ST_START = 3'd2;
    localparam ser_state_t ST_DATA  = 3'd3;
    localparam ser_state_t ST_STOP  = 3'd4;

endpackage

// File: rtl/golden_nonce_uart_tx_fifo.sv
// Nonce buffer: synchronous write, registered read, 2^FIFO_DEPTH_LOG2 entries.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module nonce_fifo
    import golden_nonce_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [NONCE_W-1:0]         wdata_i,
    output logic [NONCE_W-1:0]         rdata_o,
    output logic                       full_c_o,
    output logic                       empty_c_o,
    output logic [FIFO_DEPTH_LOG2:0]   level_o
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
    localparam int unsigned LVL_W = FIFO_DEPTH_LOG2 + 1;

    logic [NONCE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [NONCE_W-1:0] rdata_q, rdata_d;
    logic               wr_en_c, rd_en_c;

    assign full_c_o  = (level_q == LVL_W'(DEPTH));
    assign empty_c_o = (level_q == '0);
    assign rd_en_c   = pop_i && !empty_c_o;
    assign wr_en_c   = push_i && (!full_c_o || rd_en_c);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;
        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            rdata_d  = mem_q[rd_ptr_q];
        end
        case ({wr_en_c, rd_en_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage array carries no reset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = rdata_q;
    assign level_o = level_q;

endmodule

// File: rtl/golden_nonce_uart_tx.sv
// Buffers golden nonces and sends each MSB-byte-first over an 8N1 UART line.
// Build option GOLDEN_NONCE_HEADER_EN prefixes every frame with the sync byte.
module golden_nonce_uart_tx
    import golden_nonce_pkg::*;
#(
    parameter int unsigned BAUD_DIV        = 868,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic                     hash_clk,
    input  logic                     reset,
    input  logic                     golden_nonce_valid,
    input  logic [31:0]              golden_nonce,
    output logic                     uart_tx,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     overflow,
    output logic                     busy
);

`ifdef GOLDEN_NONCE_HEADER_EN
    localparam int unsigned FRAME_BYTES = NONCE_BYTES + 1;
    localparam bit          HDR_EN      = 1'b1;
`else
    localparam int unsigned FRAME_BYTES = NONCE_BYTES;
    localparam bit          HDR_EN      = 1'b0;
`endif
    localparam int unsigned          DATA_BITS   = UART_BITS_PER_BYTE - 2;
    localparam logic [BAUD_CNT_W-1:0] BAUD_RELOAD = BAUD_CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]           LAST_BYTE   = 3'(FRAME_BYTES - 1);
    localparam logic [2:0]           LAST_BIT    = 3'(DATA_BITS - 1);

    // Byte idx of the frame: optional sync byte, then nonce bytes MSB first.
    function automatic logic [7:0] frame_byte(input logic [NONCE_W-1:0] word,
                                              input logic [2:0]         idx);
        logic [2:0] nidx;
        logic [7:0] res;
        nidx = idx - 3'(HDR_EN);
        case (nidx)
            3'd0:    res = word[31:24];
            3'd1:    res = word[23:16];
            3'd2:    res = word[15:8];
            default: res = word[7:0];
        endcase
        if (HDR_EN && (idx == 3'd0)) begin
            res = NONCE_SYNC_BYTE;
        end
        return res;
    endfunction

    ser_state_t              state_q, state_d;
    logic [BAUD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]              bit_q, bit_d;
    logic [2:0]              byte_q, byte_d;
    logic [NONCE_W-1:0]      word_q, word_d;
    logic [7:0]              shreg_q, shreg_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    ovf_q, ovf_d;
    logic                    pop_c;
    logic [NONCE_W-1:0]      fifo_rdata;
    logic                    fifo_full_c, fifo_empty_c;

    nonce_fifo #(
        .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i     (hash_clk),
        .rst_i     (reset),
        .push_i    (golden_nonce_valid),
        .pop_i     (pop_c),
        .wdata_i   (golden_nonce),
        .rdata_o   (fifo_rdata),
        .full_c_o  (fifo_full_c),
        .empty_c_o (fifo_empty_c),
        .level_o   (fifo_level)
    );

    // tx_d is the line level for the state being entered, so uart_tx is a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        word_d  = word_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty_c) begin
                    pop_c   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                word_d  = fifo_rdata;
                byte_d  = 3'd0;
                shreg_d = frame_byte(fifo_rdata, 3'd0);
                cnt_d   = BAUD_RELOAD;
                tx_d    = 1'b0;
                state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = BAUD_RELOAD;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - BAUD_CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = BAUD_RELOAD;
                    if (bit_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - BAUD_CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (byte_q == LAST_BYTE) begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        shreg_d = frame_byte(word_q, byte_q + 3'd1);
                        cnt_d   = BAUD_RELOAD;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end
                end else begin
                    cnt_d = cnt_q - BAUD_CNT_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        ovf_d  = ovf_q | (golden_nonce_valid & fifo_full_c & ~pop_c);
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign uart_tx  = tx_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: doc/golden_nonce_uart_tx.md
# golden_nonce_uart_tx

Downstream consumer of the hashing core's golden-nonce result. It accepts each 32-bit golden nonce as a single-cycle valid pulse and buffers it in a small FIFO so that back-to-back finds are not lost. It then serializes each nonce over an 8N1 UART line to the host. It runs entirely in the hashing clock domain and replaces the debug-probe readout path on boards without JTAG virtual wires.

## Interface
Parameters:
- `BAUD_DIV`, default 868: hash_clk cycles per UART bit; legal range 2..65535.
- `FIFO_DEPTH_LOG2`, default 3: the FIFO holds 2^N nonces; legal range 1..6.

Ports:
- `hash_clk`  in  1  sole clock; every flop is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `golden_nonce_valid`  in  1  single-cycle strobe: `golden_nonce` is a new find.
- `golden_nonce`  in  32  corrected nonce value, sampled when valid is high.
- `uart_tx`  out  1  serial line; idles high.
- `fifo_level`  out  FIFO_DEPTH_LOG2+1  number of nonces currently buffered.
- `overflow`  out  1  sticky flag: at least one nonce was dropped.
- `busy`  out  1  high while a frame is being shifted out.

Reset values: `uart_tx`=1, `fifo_level`=0, `overflow`=0, `busy`=0.

## Operation
- **Push.** On an edge with valid high, the nonce is written if the FIFO is not full.
  - The FIFO also accepts the write when it is full but a pop occurs on the same edge.
  - Otherwise the nonce is dropped and `overflow` is set.
  - `overflow` is cleared only by `reset`.
- **Serializer FSM**, states IDLE, LOAD, START, DATA, STOP:
  - IDLE: if the FIFO is non-empty, pop and go to LOAD; otherwise stay.
  - LOAD: latch the popped word, reset the byte index, go to START.
  - START: drive 0 for BAUD_DIV cycles, then go to DATA.
  - DATA: shift out 8 bits, LSB first, BAUD_DIV cycles each, then go to STOP.
  - STOP: drive 1 for BAUD_DIV cycles. If more bytes remain in the frame, go to START; otherwise go to IDLE.
- **Byte order.** Most-significant byte first: nonce[31:24], [23:16], [15:8], [7:0].
- **`busy`** is high in every state except IDLE.
- **`uart_tx` is registered.** It is high in IDLE and LOAD.
- **Baud counter** counts BAUD_DIV-1 down to 0 and reloads on each bit boundary. Its width is 16 bits.
- **Mid-frame reset.** `uart_tx` goes high asynchronously, the FSM returns to IDLE, and the FIFO is emptied. The partially sent frame is abandoned.

## Timing
- **Empty FIFO, FSM idle, valid sampled at edge k:**
  - the word is in the FIFO after edge k;
  - it is popped at edge k+1 (IDLE→LOAD);
  - START is entered at edge k+2, so `uart_tx` is first low after edge k+2.
- **Frame length:**
  - 4 bytes × 10 bits × BAUD_DIV cycles;
  - 5 bytes × 10 bits × BAUD_DIV cycles with the header enabled.
- **Gaps.**
  - Between bytes of one frame there is no gap: STOP→START is immediate.
  - Between back-to-back frames there are exactly 2 extra idle-high cycles (IDLE and LOAD).
- **`fifo_level`** updates on the edge after the push or pop. A simultaneous push and pop leaves it unchanged.

## Configuration
- **`GOLDEN_NONCE_HEADER_EN`**
  - Defined: every frame is preceded by the sync byte 8'hA5, giving 5 bytes per frame.
  - Undefined: a frame is the 4 nonce bytes only.
  - All other behaviour is identical in both builds.

## Structure
- **`golden_nonce_pkg`:**
  - serializer state enum;
  - `NONCE_SYNC_BYTE` = 8'hA5;
  - `NONCE_BYTES` = 4;
  - `UART_BITS_PER_BYTE` = 10.
- **Sub-module `nonce_fifo`:**
  - synchronous-write, registered-read, 32-bit wide, parameter FIFO_DEPTH_LOG2;
  - ports: push, pop, data in/out, full, empty, level, async reset.
  - The serializer FSM and baud counter live in the top module.

## Test plan
All scenarios use BAUD_DIV=4 and FIFO_DEPTH_LOG2=2.
- **Single nonce.** Pulse valid with 32'h12345678 → `uart_tx` low 2 cycles after the sampling edge. Decoded bytes are 12,34,56,78 (preceded by A5 if `GOLDEN_NONCE_HEADER_EN` is defined). Each bit lasts 4 cycles. `busy` drops after the last stop bit.
- **Burst.** Pulse valid on 3 consecutive cycles with DEADBEEF, 00000001, FFFFFFFF → all three frames are sent in order. Each gap between frames is 2 high cycles. `fifo_level` peaks at 2.
- **Overflow.** Pulse 6 nonces on consecutive cycles while idle → the first 5 are sent (1 in the serializer plus 4 buffered) and the 6th is dropped. `overflow`=1 and stays set after draining.
- **Full FIFO with simultaneous pop.** With the FIFO full, push on the same edge the FSM pops → the new nonce is accepted, `fifo_level` stays 4, and `overflow` stays 0.
- **Mid-frame reset.** Assert `reset` during the DATA state of byte 2 → `uart_tx`=1 and `busy`=0 immediately, `fifo_level`=0, and no further frames are sent after deassertion.
- **Bit patterns.** Send nonces 00000000 and FFFFFFFF → decoded bytes are all 00 and all FF respectively. Stop bits are 1 and start bits are 0 in every byte.
